// File: rtl/e_mdu_pkg.sv
// rtl/e_mdu_pkg.sv - MDU op codes, latency defaults and op classification helpers
package e_mdu_pkg;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MFHI  = 4'd7,
    OP_MFLO  = 4'd8,
    OP_MADD  = 4'd9,
    OP_MADDU = 4'd10,
    OP_MSUB  = 4'd11,
    OP_MSUBU = 4'd12
  } mdu_op_e;

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_compute(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || is_div(op) ||
           (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

  function automatic logic is_signed_mul(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// rtl/e_mdu_calc.sv - combinational next-HI/LO for multiply, accumulate and divide ops
module e_mdu_calc
  import e_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] pend_hi,
  output logic [WIDTH-1:0] pend_lo
);

  localparam int W2 = 2 * WIDTH;

  logic             mul_signed;
  logic [W2-1:0]    mul_a;
  logic [W2-1:0]    mul_b;
  logic [W2-1:0]    prod;
  logic [W2-1:0]    acc;

  // Extending both operands to 2*WIDTH makes the truncated product correct for either signedness.
  assign mul_signed = is_signed_mul(op);
  assign mul_a      = mul_signed ? {{WIDTH{data1[WIDTH-1]}}, data1} : {{WIDTH{1'b0}}, data1};
  assign mul_b      = mul_signed ? {{WIDTH{data2[WIDTH-1]}}, data2} : {{WIDTH{1'b0}}, data2};
  assign prod       = mul_a * mul_b;
  assign acc        = {hi, lo};

  logic             div_signed;
  logic             neg_num;
  logic             neg_den;
  logic [WIDTH-1:0] num;
  logic [WIDTH-1:0] den;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] r_mag;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  // One unsigned divider on magnitudes; MIN_INT / -1 wraps back to MIN_INT with remainder 0.
  assign div_signed = (op == OP_DIV);
  assign neg_num    = div_signed && data1[WIDTH-1];
  assign neg_den    = div_signed && data2[WIDTH-1];
  assign num        = neg_num ? (~data1 + 1'b1) : data1;
  assign den        = neg_den ? (~data2 + 1'b1) : data2;
  assign q_mag      = num / den;
  assign r_mag      = num % den;
  assign quo        = (neg_num ^ neg_den) ? (~q_mag + 1'b1) : q_mag;
  assign rem        = neg_num ? (~r_mag + 1'b1) : r_mag;

  always_comb begin
    pend_hi = hi;
    pend_lo = lo;
    case (op)
      OP_MULT, OP_MULTU: {pend_hi, pend_lo} = prod;
      OP_MADD, OP_MADDU: {pend_hi, pend_lo} = acc + prod;
      OP_MSUB, OP_MSUBU: {pend_hi, pend_lo} = acc - prod;
      OP_DIV, OP_DIVU: begin
        if (data2 != '0) begin
          pend_hi = rem;
          pend_lo = quo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - E-stage multiply/divide unit holding HI/LO with a fixed-latency busy window
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_start,
  input  logic [3:0]       E_mdu_op,
  input  logic [WIDTH-1:0] E_data1,
  input  logic [WIDTH-1:0] E_data2,
  output logic             E_busy,
  output logic [WIDTH-1:0] E_hi,
  output logic [WIDTH-1:0] E_lo,
  output logic [WIDTH-1:0] E_mdu_out
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] pend_hi;
  logic [WIDTH-1:0] pend_lo;
  logic [WIDTH-1:0] calc_hi;
  logic [WIDTH-1:0] calc_lo;
  logic             idle;
  logic             accept;

  assign idle   = (cnt == '0);
  assign accept = E_start && idle && is_compute(E_mdu_op);

  e_mdu_calc #(
    .WIDTH(WIDTH)
  ) u_calc (
    .op      (E_mdu_op),
    .data1   (E_data1),
    .data2   (E_data2),
    .hi      (hi),
    .lo      (lo),
    .pend_hi (calc_hi),
    .pend_lo (calc_lo)
  );

  // The result is latched at accept and only committed when the countdown expires, so HI/LO
  // keep their old value for the whole busy window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (accept) begin
      cnt     <= is_div(E_mdu_op) ? DIV_CNT : MUL_CNT;
      pend_hi <= calc_hi;
      pend_lo <= calc_lo;
    end else if (!idle) begin
      cnt <= cnt - ONE_CNT;
      if (cnt == ONE_CNT) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (E_start) begin
      if (E_mdu_op == OP_MTHI) hi <= E_data1;
      if (E_mdu_op == OP_MTLO) lo <= E_data1;
    end
  end

  assign E_busy = !idle;
  assign E_hi   = hi;
  assign E_lo   = lo;

  always_comb begin
    E_mdu_out = '0;
    case (E_mdu_op)
      OP_MFHI: E_mdu_out = hi;
      OP_MFLO: E_mdu_out = lo;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - vector table, corner sequences and random ops against an arithmetic model
module tb_e_mdu;
  import e_mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E_start = 1'b0;
  logic [3:0]  E_mdu_op = 4'd0;
  logic [31:0] E_data1 = '0;
  logic [31:0] E_data2 = '0;
  logic        E_busy;
  logic [31:0] E_hi;
  logic [31:0] E_lo;
  logic [31:0] E_mdu_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu dut (
    .clk       (clk),
    .reset     (reset),
    .E_start   (E_start),
    .E_mdu_op  (E_mdu_op),
    .E_data1   (E_data1),
    .E_data2   (E_data2),
    .E_busy    (E_busy),
    .E_hi      (E_hi),
    .E_lo      (E_lo),
    .E_mdu_out (E_mdu_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    E_start  = 1'b1;
    E_mdu_op = op;
    E_data1  = a;
    E_data2  = b;
    @(negedge clk);
    E_start  = 1'b0;
    E_mdu_op = OP_NOP;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (E_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  function automatic int exp_cycles(input logic [3:0] op);
    if (op == OP_DIV || op == OP_DIVU) return 10;
    if (op == OP_MULT || op == OP_MULTU || (op >= OP_MADD && op <= OP_MSUBU)) return 5;
    return 0;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural {HI,LO} pair.
  task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] acc, ps, pu;
    longint      sq, sr;
    acc = {m_hi, m_lo};
    ps  = 64'(longint'(int'(a)) * longint'(int'(b)));
    pu  = {32'd0, a} * {32'd0, b};
    case (op)
      OP_MULT:  {m_hi, m_lo} = ps;
      OP_MULTU: {m_hi, m_lo} = pu;
      OP_MADD:  {m_hi, m_lo} = acc + ps;
      OP_MADDU: {m_hi, m_lo} = acc + pu;
      OP_MSUB:  {m_hi, m_lo} = acc - ps;
      OP_MSUBU: {m_hi, m_lo} = acc - pu;
      OP_DIV: if (b != 0) begin
        sq   = longint'(int'(a)) / longint'(int'(b));
        sr   = longint'(int'(a)) % longint'(int'(b));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      OP_DIVU: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #100_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rops[10];
    rops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
             OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};

    vecs[0]  = '{OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{OP_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, 5};
    vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{OP_MTHI,  32'h11,        32'd0,         32'h11,        32'hFFFF_FFFD, 0};
    vecs[4]  = '{OP_MTLO,  32'h22,        32'd0,         32'h11,        32'h22,        0};
    vecs[5]  = '{OP_DIVU,  32'd7,         32'd0,         32'h11,        32'h22,        10};
    vecs[6]  = '{OP_MTLO,  32'd5,         32'd0,         32'h11,        32'd5,         0};
    vecs[7]  = '{OP_MTHI,  32'd0,         32'd0,         32'd0,         32'd5,         0};
    vecs[8]  = '{OP_MADD,  32'd3,         32'd4,         32'd0,         32'd17,        5};
    vecs[9]  = '{OP_MSUB,  32'd10,        32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 5};
    vecs[10] = '{OP_MFLO,  32'd0,         32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0};
    vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10};
    vecs[12] = '{OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h8000_0001, 5};
    vecs[13] = '{OP_MSUBU, 32'd1,         32'd1,         32'hFFFF_FFFE, 32'h8000_0000, 5};
    vecs[14] = '{4'd13,    32'h1234,      32'h5678,      32'hFFFF_FFFE, 32'h8000_0000, 0};

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, E_busy}, 32'd0);
    check("reset_hi", E_hi, 32'd0);
    check("reset_lo", E_lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("nop_out", E_mdu_out, 32'd0);

    for (int i = 0; i < 15; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_idle(n);
      check($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cyc));
      check($sformatf("vec%0d_hi", i), E_hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), E_lo, vecs[i].lo);
      E_mdu_op = OP_MFHI;
      #1 check($sformatf("vec%0d_mfhi", i), E_mdu_out, vecs[i].hi);
      E_mdu_op = OP_MFLO;
      #1 check($sformatf("vec%0d_mflo", i), E_mdu_out, vecs[i].lo);
      E_mdu_op = OP_NOP;
    end

    // MULT and MTHI arriving while a DIV is busy must be dropped.
    issue(OP_DIV, 32'd100, 32'd7);
    E_start  = 1'b1;
    E_mdu_op = OP_MULT;
    E_data1  = 32'd9;
    E_data2  = 32'd9;
    @(negedge clk);
    E_mdu_op = OP_MTHI;
    E_data1  = 32'hDEAD;
    @(negedge clk);
    E_start  = 1'b0;
    E_mdu_op = OP_NOP;
    wait_idle(n);
    check("busy_ign_cycles", 32'(n + 2), 32'd10);
    check("busy_ign_hi", E_hi, 32'd2);
    check("busy_ign_lo", E_lo, 32'd14);

    // Held MADD: ignored on the completion edge, re-accepted on the following one.
    issue(OP_MTHI, 32'd0, 32'd0);
    issue(OP_MTLO, 32'd0, 32'd0);
    @(negedge clk);
    E_start  = 1'b1;
    E_mdu_op = OP_MADD;
    E_data1  = 32'd3;
    E_data2  = 32'd5;
    repeat (6) @(negedge clk);
    check("held_first_busy", {31'd0, E_busy}, 32'd0);
    check("held_first_lo", E_lo, 32'd15);
    @(negedge clk);
    check("held_second_busy", {31'd0, E_busy}, 32'd1);
    E_start  = 1'b0;
    E_mdu_op = OP_NOP;
    wait_idle(n);
    check("held_second_cycles", 32'(n), 32'd5);
    check("held_second_lo", E_lo, 32'd30);
    check("held_second_hi", E_hi, 32'd0);

    // Asynchronous reset in the middle of a DIV.
    issue(OP_MTHI, 32'h55, 32'd0);
    issue(OP_DIV, 32'd50, 32'd3);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, E_busy}, 32'd0);
    check("rst_mid_hi", E_hi, 32'd0);
    check("rst_mid_lo", E_lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    E_mdu_op = OP_MFHI;
    #1 check("rst_mfhi", E_mdu_out, 32'd0);
    E_mdu_op = OP_NOP;
    repeat (12) @(negedge clk);
    check("rst_no_commit_lo", E_lo, 32'd0);

    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 300; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = rops[$urandom_range(0, 9)];
      a  = pick_operand();
      b  = pick_operand();
      issue(op, a, b);
      model_step(op, a, b);
      wait_idle(n);
      check($sformatf("rnd%0d_cycles op%0d", i, op), 32'(n), 32'(exp_cycles(op)));
      check($sformatf("rnd%0d_hi op%0d a%08h b%08h", i, op, a, b), E_hi, m_hi);
      check($sformatf("rnd%0d_lo op%0d a%08h b%08h", i, op, a, b), E_lo, m_lo);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
